// File: rtl/led_pkg.sv
// Shared types and constants for the LED arbiter.
// Holds the FSM state enum, requester count, pattern width and a counter-width helper.
package led_pkg;

   localparam int N_REQ = 4;
   localparam int PAT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_GAP
   } state_t;

   // Width able to hold 0..n; never below one bit so n=0 stays legal.
   function automatic int cw(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV sys_clk cycles.
// Ports: sys_clk, sys_rst (async, active high), tick (high while count is TICK_DIV-1).
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic tick
);

   localparam int CW = cw(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (tick) cnt_d = '0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing one 2-bit LED between four requesters.
// Ports: sys_clk, sys_rst (async, active high), req[3:0], req_pat[7:0],
//        gnt[3:0] (one-hot, registered), led[1:0] (registered), busy.
module led_arbiter
   import led_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int HOLD_TICKS  = 500,
   parameter int BLINK_TICKS = 250,
   parameter int GAP_TICKS   = 50
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*PAT_W-1:0]   req_pat,
   output logic [N_REQ-1:0]         gnt,
   output logic [PAT_W-1:0]         led,
   output logic                     busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = cw(HOLD_TICKS);
   localparam int BW = cw(BLINK_TICKS);
   localparam int GW = cw(GAP_TICKS);

   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS);
   localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TICKS);

   logic tick;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tick    (tick)
   );

   state_t            state_q, state_d;
   logic [IW-1:0]     win_q,   win_d;
   logic [PAT_W-1:0]  pat_q,   pat_d;
   logic [HW-1:0]     hold_q,  hold_d;
   logic [BW-1:0]     blink_q, blink_d;
   logic              phase_q, phase_d;
   logic [GW-1:0]     gap_q,   gap_d;
   logic [N_REQ-1:0]  gnt_q,   gnt_d;
   logic [PAT_W-1:0]  led_q,   led_d;

   logic              found;
   logic [IW-1:0]     pick;
   logic [IW-1:0]     idx;

   // Search starts one past the last winner; k=N_REQ wraps back to it.
   always_comb begin
      found = 1'b0;
      pick  = win_q;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = win_q + IW'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      pat_d   = pat_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      phase_d = phase_q;
      gap_d   = gap_q;

      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_GRANT;
               win_d   = pick;
               pat_d   = req_pat[pick*PAT_W +: PAT_W];
               hold_d  = '0;
               blink_d = '0;
               phase_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (tick) begin
               if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
               if (blink_q + 1'b1 >= BLINK_MAX) begin
                  blink_d = '0;
                  phase_d = ~phase_q;
               end else begin
                  blink_d = blink_q + 1'b1;
               end
            end
            // Release and hold expiry share one exit.
            if (!req[win_q] || hold_d == HOLD_MAX) begin
               state_d = ST_GAP;
               gap_d   = '0;
            end
         end
         ST_GAP: begin
            if (tick && gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
            // GAP_MAX=0 leaves on the first edge.
            if (gap_d == GAP_MAX) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs follow the next state so they register with it.
      gnt_d = '0;
      led_d = '0;
      if (state_d == ST_GRANT) begin
         gnt_d[win_d] = 1'b1;
         if (phase_d) led_d = pat_d;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         win_q   <= IW'(N_REQ - 1);
         pat_q   <= '0;
         hold_q  <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
         gap_q   <= '0;
         gnt_q   <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         pat_q   <= pat_d;
         hold_q  <= hold_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         gap_q   <= gap_d;
         gnt_q   <= gnt_d;
         led_q   <= led_d;
      end
   end

   assign gnt  = gnt_q;
   assign led  = led_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, sys_clk cycles per tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 500, maximum ticks one grant is held.
REQ-003 SHALL have parameter BLINK_TICKS, default 250, ticks per blink half-period.
REQ-004 SHALL have parameter GAP_TICKS, default 50, ticks of dark LED between grants.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port sys_clk, input, 1, system clock; all state on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req, input, 4, per-requester LED request, level-sensitive.
REQ-009 SHALL have port req_pat, input, 8, 2-bit pattern per requester; bits [2i+1:2i] belong to requester i.
REQ-010 SHALL have port gnt, output, 4, one-hot grant, registered.
REQ-011 SHALL have port led, output, 2, LED drive, registered.
REQ-012 SHALL have port busy, output, 1, high in GRANT or GAP.

Function
REQ-013 SHALL use a free-running prescaler producing a 1-cycle tick pulse every TICK_DIV cycles, wrapping at TICK_DIV-1 to 0.
REQ-014 SHALL implement FSM IDLE, GRANT, GAP.
REQ-015 IDLE: led=00 and gnt=0000; if any req bit is high, the winner SHALL be chosen round-robin, starting at last_winner+1 mod 4 and wrapping 3->0.
REQ-016 IDLE->GRANT: a req seen high at edge N SHALL give gnt and the GRANT state at edge N+1.
REQ-017 On the grant edge SHALL latch the winner's req_pat, clear the hold and blink counters, set blink phase to 1, and update last_winner.
REQ-018 Changes to req_pat during GRANT SHALL be ignored.
REQ-019 GRANT: led SHALL equal the latched pattern when blink phase is 1 and 00 otherwise.
REQ-020 GRANT: blink phase SHALL toggle after every BLINK_TICKS ticks.
REQ-021 GRANT: the hold counter SHALL count ticks.
REQ-022 GRANT->GAP SHALL occur on the edge where the hold count reaches HOLD_TICKS or the granted req bit is low, whichever comes first; if both occur together, one transition to GAP.
REQ-023 On GRANT->GAP, led and gnt SHALL clear on the same edge.
REQ-024 Requests from other requesters during GRANT SHALL wait; they are never pre-empted or lost while held high.
REQ-025 GAP: led=00; after GAP_TICKS ticks SHALL go to IDLE.
REQ-026 GAP_TICKS=0 SHALL go to IDLE on the next edge.
REQ-027 Counter widths SHALL be $clog2(param+1); counters saturate, never wrap, in GRANT and GAP.
REQ-028 gnt SHALL always be one-hot or zero.

Reset
REQ-029 sys_rst high SHALL force immediately, asynchronously: state IDLE, gnt=0000, led=00, busy=0, last_winner=3 (first grant goes to requester 0), prescaler and all counters 0, blink phase 0.
REQ-030 Reset asserted mid-grant SHALL abort the grant without a GAP period.
REQ-031 On reset release, arbitration SHALL resume from the first edge.

Structure
REQ-032 Package led_pkg SHALL hold the FSM state enum, N_REQ=4 and PAT_W=2.
REQ-033 The prescaler SHALL be sub-module led_tick_gen (parameter TICK_DIV, output tick).
REQ-034 Arbitration and blink logic SHALL be in led_arbiter.

Verification (TICK_DIV=4, HOLD_TICKS=8, BLINK_TICKS=2, GAP_TICKS=1)
REQ-035 Bench SHALL cover: after reset, req=0001, pat0=10 -> gnt=0001 one cycle later; led toggles 10/00 every 8 cycles; release after 32 cycles; then GAP 4 cycles, then IDLE.
REQ-036 Bench SHALL cover: req=1111 held -> grants in order 0001,0010,0100,1000,0001, each followed by a GAP.
REQ-037 Bench SHALL cover: req1 dropped mid-grant -> gnt and led go to 0 on the next edge; GAP; next grant goes to the next requester in round-robin order.
REQ-038 Bench SHALL cover: req_pat changed during GRANT -> led keeps the latched pattern.
REQ-039 Bench SHALL cover: sys_rst pulsed mid-GRANT, asynchronous to sys_clk -> led=00 and gnt=0000 without waiting for a clock edge; with req=0100 held, first grant after release is 0100.
REQ-040 Bench SHALL cover: req drop on the same edge as hold expiry -> exactly one GAP entry; gnt is never non-one-hot (checked by assertion).
